// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Sequencer that sits directly upstream of the arithmetic testbench. A run goes
// through these steps:
//   1. Hold the testbench in reset for CLEAR_CYCLES cycles.
//   2. Enable stimulus until the testbench data counter reaches the requested
//      vector count, or until that counter stops moving for too long.
//   3. Drop the enable and let the DUT/driver pipeline drain for DRAIN_CYCLES.
//   4. Freeze the scoreboard and report the captured results.
// The host talks to the block through a start/busy/done handshake.
//
// Parameters:
//   WIDTH         width of the counters and of the test-count request
//   CLEAR_CYCLES  cycles the testbench reset is held at the start of a run (>=1)
//   DRAIN_CYCLES  cycles between the enable drop and the freeze (>=1)
//   TIMEOUT       RUN cycles allowed without i_data_ctr changing (>=2)
//
// Ports:
//   clk            single clock, shared with the testbench and DUT
//   reset          asynchronous, active-high
//   i_start        single-cycle run request, honoured in IDLE and DONE only
//   i_abort        cancel the run in progress (CLEAR/RUN/DRAIN), back to IDLE
//   i_num_tests    number of vectors to run, sampled on the accepted i_start
//   i_data_ctr     testbench data counter
//   i_event_ctr    testbench event (error) counter
//   o_tb_reset     testbench reset
//   o_tb_enable    testbench enable
//   o_tb_freeze    testbench freeze
//   o_busy         high in CLEAR, RUN and DRAIN
//   o_done         high in DONE
//   o_pass         valid with o_done: no errors and no timeout
//   o_timeout      valid with o_done: run ended by watchdog timeout
//   o_error_count  i_event_ctr captured on entry to DONE
//   o_tested       i_data_ctr captured on entry to DONE
//
// Every output is a register. The handshake and testbench controls are decoded
// from the next state, so they change on the same edge as the state itself.
// -----------------------------------------------------------------------------
module run_controller #(
  parameter int WIDTH        = 32,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_num_tests,
  input  logic [WIDTH-1:0] i_data_ctr,
  input  logic [WIDTH-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_tb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic [WIDTH-1:0] o_error_count,
  output logic [WIDTH-1:0] o_tested
);

  // One phase counter is shared by CLEAR and DRAIN. It only has to count up
  // to the larger of the two lengths minus one.
  localparam int CNT_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int WD_W    = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_ZERO    = WD_W'(0);
  localparam logic [WD_W-1:0]  WD_ONE     = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] W_ZERO     = WIDTH'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] prev_data_q, prev_data_d;
  logic             to_flag_q, to_flag_d;

  logic             tb_reset_q, tb_reset_d;
  logic             tb_enable_q, tb_enable_d;
  logic             tb_freeze_q, tb_freeze_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] tested_q, tested_d;

  logic             data_changed_s;
  logic             target_hit_s;
  logic [WD_W-1:0]  wd_next_s;

  assign data_changed_s = (i_data_ctr != prev_data_q);
  assign target_hit_s   = (i_data_ctr >= target_q);

  // Watchdog step: it restarts on any data counter movement and otherwise
  // counts up, saturating at its terminal value instead of wrapping.
  always_comb begin
    wd_next_s = wd_q;
    if (data_changed_s) begin
      wd_next_s = WD_ZERO;
    end else if (wd_q != WD_LAST) begin
      wd_next_s = wd_q + WD_ONE;
    end else begin
      wd_next_s = wd_q;
    end
  end

  // Next-state and result computation for the run sequencer.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    to_flag_d   = to_flag_q;
    prev_data_d = i_data_ctr;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    tested_d    = tested_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // i_abort has no effect here, only i_start is looked at.
        if (i_start) begin
          target_d  = i_num_tests;
          cnt_d     = CNT_ZERO;
          wd_d      = WD_ZERO;
          to_flag_d = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          if (i_num_tests == W_ZERO) begin
            // An empty run completes at once and counts as a pass.
            state_d  = ST_DONE;
            pass_d   = 1'b1;
            err_d    = W_ZERO;
            tested_d = W_ZERO;
          end else begin
            state_d = ST_CLEAR;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_CLEAR: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CLEAR_LAST) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
          wd_d    = WD_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (target_hit_s) begin
          // Reaching the target beats a watchdog expiry in the same cycle.
          state_d   = ST_DRAIN;
          to_flag_d = 1'b0;
          cnt_d     = CNT_ZERO;
          wd_d      = wd_next_s;
        end else if (wd_next_s == WD_LAST) begin
          state_d   = ST_DRAIN;
          to_flag_d = 1'b1;
          cnt_d     = CNT_ZERO;
          wd_d      = wd_next_s;
        end else begin
          wd_d = wd_next_s;
        end
      end

      ST_DRAIN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DRAIN_LAST) begin
          // Pipeline has drained, so the counters now hold final values.
          state_d   = ST_DONE;
          err_d     = i_event_ctr;
          tested_d  = i_data_ctr;
          pass_d    = (i_event_ctr == W_ZERO) && !to_flag_q;
          timeout_d = to_flag_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Testbench controls and handshake flags decoded from the state being entered.
  always_comb begin
    tb_reset_d  = 1'b1;
    tb_enable_d = 1'b0;
    tb_freeze_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE: begin
        tb_reset_d = 1'b1;
      end
      ST_CLEAR: begin
        tb_reset_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_RUN: begin
        tb_reset_d  = 1'b0;
        tb_enable_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DRAIN: begin
        tb_reset_d = 1'b0;
        busy_d     = 1'b1;
      end
      ST_DONE: begin
        tb_reset_d  = 1'b0;
        tb_freeze_d = 1'b1;
        done_d      = 1'b1;
      end
      default: begin
        tb_reset_d = 1'b1;
      end
    endcase
  end

  // Sequencer state, internal counters and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= W_ZERO;
      cnt_q       <= CNT_ZERO;
      wd_q        <= WD_ZERO;
      prev_data_q <= W_ZERO;
      to_flag_q   <= 1'b0;
      tb_reset_q  <= 1'b1;
      tb_enable_q <= 1'b0;
      tb_freeze_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= W_ZERO;
      tested_q    <= W_ZERO;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      prev_data_q <= prev_data_d;
      to_flag_q   <= to_flag_d;
      tb_reset_q  <= tb_reset_d;
      tb_enable_q <= tb_enable_d;
      tb_freeze_q <= tb_freeze_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      tested_q    <= tested_d;
    end
  end

  assign o_tb_reset    = tb_reset_q;
  assign o_tb_enable   = tb_enable_q;
  assign o_tb_freeze   = tb_freeze_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_timeout     = timeout_q;
  assign o_error_count = err_q;
  assign o_tested      = tested_q;

endmodule
